// File: rtl/nunchuck_event_decoder.sv
// Turns nunchuck reports into debounced, single-cycle direction/button events with
// hysteresis, long-press and stale-link detection. Auto-repeat: define NUNCHUCK_AUTOREPEAT_EN.
module nunchuck_event_decoder #(
  parameter logic [7:0] HI_THRESH    = 8'd200,
  parameter logic [7:0] LO_THRESH    = 8'd56,
  parameter logic [7:0] HYST         = 8'd16,
  parameter int         DEB_SAMPLES  = 3,
  parameter int         REPEAT_DELAY = 50,
  parameter int         REPEAT_RATE  = 10,
  parameter int         LONG_SAMPLES = 100,
  parameter int         STALE_CYCLES = 1_000_000
) (
  input  logic       i2c_clock,
  input  logic       rst,
  input  logic       sample_stb,
  input  logic [7:0] stick_x,
  input  logic [7:0] stick_y,
  input  logic       z,
  input  logic       c,
  output logic       ev_up,
  output logic       ev_down,
  output logic       ev_left,
  output logic       ev_right,
  output logic       ev_z,
  output logic       ev_c,
  output logic       ev_z_long,
  output logic [2:0] dir_held,
  output logic       stale
);

  localparam int SW = $clog2(STALE_CYCLES + 1);
  localparam int LW = $clog2(LONG_SAMPLES + 1);
  localparam logic [3:0] DEB_N = 4'(DEB_SAMPLES);

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {NEU, POS, NEG} zone_t;

  function automatic zone_t zone_step(input zone_t cur, input logic [7:0] v);
    zone_t nxt;
    nxt = cur;
    case (cur)
      NEU: begin
        if (v >= HI_THRESH)      nxt = POS;
        else if (v <= LO_THRESH) nxt = NEG;
      end
      POS: begin
        if (v <= LO_THRESH)                 nxt = NEG;
        else if (v < (HI_THRESH - HYST))    nxt = NEU;
      end
      NEG: begin
        if (v >= HI_THRESH)                 nxt = POS;
        else if (v > (LO_THRESH + HYST))    nxt = NEU;
      end
      default: nxt = NEU;
    endcase
    return nxt;
  endfunction

  // ---------------- stale link ----------------
  logic [SW-1:0] stale_cnt_reg, stale_cnt_next;
  logic          stale_hit;
  logic          stale_next;

  assign stale_hit = !sample_stb && (stale_cnt_reg == SW'(STALE_CYCLES - 1));

  always_comb begin
    stale_cnt_next = stale_cnt_reg;
    stale_next     = stale;
    if (sample_stb) begin
      stale_cnt_next = '0;
      stale_next     = 1'b0;
    end else begin
      if (stale_cnt_reg != SW'(STALE_CYCLES)) stale_cnt_next = stale_cnt_reg + SW'(1);
      if (stale_hit) stale_next = 1'b1;
    end
  end

  // ---------------- zones and candidate ----------------
  zone_t zone_x_reg, zone_y_reg, zone_x_step, zone_y_step, zone_x_next, zone_y_next;
  logic signed [8:0] dx, dy;
  logic [8:0] mag_x, mag_y;
  logic [2:0] cand_dir;

  assign zone_x_step = zone_step(zone_x_reg, stick_x);
  assign zone_y_step = zone_step(zone_y_reg, stick_y);
  assign zone_x_next = stale_hit ? NEU : (sample_stb ? zone_x_step : zone_x_reg);
  assign zone_y_next = stale_hit ? NEU : (sample_stb ? zone_y_step : zone_y_reg);

  assign dx    = $signed({1'b0, stick_x}) - 9'sd128;
  assign dy    = $signed({1'b0, stick_y}) - 9'sd128;
  assign mag_x = dx[8] ? $unsigned(-dx) : $unsigned(dx);
  assign mag_y = dy[8] ? $unsigned(-dy) : $unsigned(dy);

  // Ties between two active axes go to X.
  always_comb begin
    cand_dir = DIR_NONE;
    if ((zone_x_step != NEU) && ((zone_y_step == NEU) || (mag_x >= mag_y)))
      cand_dir = (zone_x_step == POS) ? DIR_RIGHT : DIR_LEFT;
    else if (zone_y_step != NEU)
      cand_dir = (zone_y_step == POS) ? DIR_UP : DIR_DOWN;
  end

  // ---------------- debounce: ch0 direction, ch1 z, ch2 c ----------------
  logic [8:0] deb_in;
  logic [8:0] acc_flat;
  logic [8:0] acc_next_flat;

  assign deb_in = {2'b00, c, 2'b00, z, cand_dir};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      logic [2:0] din;
      logic [2:0] last_reg, last_next, acc_reg, acc_next;
      logic [3:0] cnt_reg, cnt_next;

      assign din = deb_in[gi*3 +: 3];

      always_comb begin
        last_next = last_reg;
        acc_next  = acc_reg;
        cnt_next  = cnt_reg;
        if (stale_hit) begin
          last_next = '0;
          acc_next  = '0;
          cnt_next  = '0;
        end else if (sample_stb) begin
          if (din == last_reg) cnt_next = (cnt_reg == 4'hF) ? cnt_reg : cnt_reg + 4'd1;
          else                 cnt_next = 4'd1;
          last_next = din;
          if (cnt_next >= DEB_N) acc_next = din;
        end
      end

      always_ff @(posedge i2c_clock or posedge rst) begin
        if (rst) begin
          last_reg <= '0;
          acc_reg  <= '0;
          cnt_reg  <= '0;
        end else begin
          last_reg <= last_next;
          acc_reg  <= acc_next;
          cnt_reg  <= cnt_next;
        end
      end

      assign acc_flat[gi*3 +: 3]      = acc_reg;
      assign acc_next_flat[gi*3 +: 3] = acc_next;
    end
  endgenerate

  logic [2:0] dir_acc_reg, dir_acc_next;
  logic       z_acc_reg, z_acc_next, c_acc_reg, c_acc_next;

  assign dir_acc_reg  = acc_flat[2:0];
  assign dir_acc_next = acc_next_flat[2:0];
  assign z_acc_reg    = (acc_flat[5:3] != 3'd0);
  assign z_acc_next   = (acc_next_flat[5:3] != 3'd0);
  assign c_acc_reg    = (acc_flat[8:6] != 3'd0);
  assign c_acc_next   = (acc_next_flat[8:6] != 3'd0);

  // ---------------- direction FSM ----------------
  logic [2:0] pulse_dir;

`ifdef NUNCHUCK_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} dir_state_t;
  dir_state_t dir_state_reg, dir_state_next;
  logic [RW-1:0] rep_cnt_reg, rep_cnt_next, rep_inc;

  always_comb begin
    dir_state_next = dir_state_reg;
    rep_cnt_next   = rep_cnt_reg;
    rep_inc        = rep_cnt_reg + RW'(1);
    pulse_dir      = DIR_NONE;
    if (stale_hit) begin
      dir_state_next = IDLE;
      rep_cnt_next   = '0;
    end else if (sample_stb) begin
      if (dir_acc_next == DIR_NONE) begin
        dir_state_next = IDLE;
        rep_cnt_next   = '0;
      end else if ((dir_acc_next != dir_acc_reg) || (dir_state_reg == IDLE)) begin
        pulse_dir      = dir_acc_next;
        dir_state_next = DELAY;
        rep_cnt_next   = '0;
      end else begin
        rep_cnt_next = rep_inc;
        if ((dir_state_reg == DELAY) && (rep_inc == RW'(REPEAT_DELAY))) begin
          pulse_dir      = dir_acc_next;
          dir_state_next = REPEAT;
          rep_cnt_next   = '0;
        end else if ((dir_state_reg == REPEAT) && (rep_inc == RW'(REPEAT_RATE))) begin
          pulse_dir    = dir_acc_next;
          rep_cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge i2c_clock or posedge rst) begin
    if (rst) begin
      dir_state_reg <= IDLE;
      rep_cnt_reg   <= '0;
    end else begin
      dir_state_reg <= dir_state_next;
      rep_cnt_reg   <= rep_cnt_next;
    end
  end
`else
  typedef enum logic [1:0] {IDLE, HELD} dir_state_t;
  dir_state_t dir_state_reg, dir_state_next;
  // Repeat timing has no effect when auto-repeat is compiled out.
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = 32'(REPEAT_DELAY) ^ 32'(REPEAT_RATE);

  always_comb begin
    dir_state_next = dir_state_reg;
    pulse_dir      = DIR_NONE;
    if (stale_hit) begin
      dir_state_next = IDLE;
    end else if (sample_stb) begin
      if (dir_acc_next == DIR_NONE) begin
        dir_state_next = IDLE;
      end else if ((dir_acc_next != dir_acc_reg) || (dir_state_reg == IDLE)) begin
        pulse_dir      = dir_acc_next;
        dir_state_next = HELD;
      end
    end
  end

  always_ff @(posedge i2c_clock or posedge rst) begin
    if (rst) dir_state_reg <= IDLE;
    else     dir_state_reg <= dir_state_next;
  end
`endif

  // ---------------- buttons and long press ----------------
  logic [LW-1:0] long_cnt_reg, long_cnt_next;
  logic          long_hit, z_rise, c_rise;

  assign z_rise = sample_stb && z_acc_next && !z_acc_reg;
  assign c_rise = sample_stb && c_acc_next && !c_acc_reg;

  always_comb begin
    long_cnt_next = long_cnt_reg;
    long_hit      = 1'b0;
    if (stale_hit) begin
      long_cnt_next = '0;
    end else if (sample_stb) begin
      if (!z_acc_next) begin
        long_cnt_next = '0;
      end else if (long_cnt_reg != LW'(LONG_SAMPLES)) begin
        long_cnt_next = long_cnt_reg + LW'(1);
        long_hit      = (long_cnt_reg == LW'(LONG_SAMPLES - 1));
      end
    end
  end

  always_ff @(posedge i2c_clock or posedge rst) begin
    if (rst) begin
      zone_x_reg    <= NEU;
      zone_y_reg    <= NEU;
      stale_cnt_reg <= '0;
      long_cnt_reg  <= '0;
      stale         <= 1'b0;
      ev_up         <= 1'b0;
      ev_down       <= 1'b0;
      ev_left       <= 1'b0;
      ev_right      <= 1'b0;
      ev_z          <= 1'b0;
      ev_c          <= 1'b0;
      ev_z_long     <= 1'b0;
    end else begin
      zone_x_reg    <= zone_x_next;
      zone_y_reg    <= zone_y_next;
      stale_cnt_reg <= stale_cnt_next;
      long_cnt_reg  <= long_cnt_next;
      stale         <= stale_next;
      ev_up         <= (pulse_dir == DIR_UP);
      ev_down       <= (pulse_dir == DIR_DOWN);
      ev_left       <= (pulse_dir == DIR_LEFT);
      ev_right      <= (pulse_dir == DIR_RIGHT);
      ev_z          <= z_rise;
      ev_c          <= c_rise;
      ev_z_long     <= long_hit;
    end
  end

  assign dir_held = dir_acc_reg;

endmodule
